multi_cycle_control_fsm: RTL and testbench

Control state machine for the multi-cycle RV32I core. It sequences a shared datapath of one unified memory, one ALU, and the IR, A, B, ALUOut and MDR registers through fetch, decode, execute, memory and write-back steps. It replaces the single-cycle opcode decoder and drives every datapath mux select and write enable, one cycle at a time. It waits on a memory ready handshake and detects the halt ecall.

---
 rtl/multi_cycle_control_fsm.sv | 257 +++++++++++++++++++++++++
 tb/tb_multi_cycle_control_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control_fsm
// Brief    : Multi-cycle RV32I control FSM that sequences the shared datapath.
//            The MC_CTRL_PERF_CNT_EN macro enables the cycle and retired
//            instruction counters.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             alu_bcond,
    input  logic             x17_is_10,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             is_halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_PC4  = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_ECALL  = 7'b1110011;

    localparam logic [1:0] c_SRCB_B   = 2'b00;
    localparam logic [1:0] c_SRCB_4   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM = 2'b10;

    localparam logic [1:0] c_ALU_ADD    = 2'b00;
    localparam logic [1:0] c_ALU_BRANCH = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT  = 2'b10;

    state_t r_state;
    state_t w_next_state;
    logic   r_started;

    logic       w_pc_write;
    logic       w_pc_source;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_live;

    logic w_is_r, w_is_i, w_is_load, w_is_store;
    logic w_is_branch, w_is_jal, w_is_jalr, w_is_ecall;

    assign w_is_r      = (opcode == c_OP_R);
    assign w_is_i      = (opcode == c_OP_I);
    assign w_is_load   = (opcode == c_OP_LOAD);
    assign w_is_store  = (opcode == c_OP_STORE);
    assign w_is_branch = (opcode == c_OP_BRANCH);
    assign w_is_jal    = (opcode == c_OP_JAL);
    assign w_is_jalr   = (opcode == c_OP_JALR);
    assign w_is_ecall  = (opcode == c_OP_ECALL);

    // r_started holds the machine idle for the first cycle after reset release,
    // so the first fetch request shows up one cycle after deassertion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IF;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_started <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_pc_source  = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = c_SRCB_B;
        w_alu_op     = c_ALU_ADD;

        case (r_state)
            S_IF: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_next_state = S_ID;
                end
            end

            S_ID: begin
                w_alu_src_b = c_SRCB_IMM;
                if (w_is_ecall)
                    w_next_state = x17_is_10 ? S_HALT : S_PC4;
                else if (w_is_jal)
                    w_next_state = S_WB;
                else if (w_is_r || w_is_i || w_is_load || w_is_store ||
                         w_is_branch || w_is_jalr)
                    w_next_state = S_EX;
                else
                    w_next_state = S_PC4;
            end

            S_EX: begin
                w_alu_src_a = 1'b1;
                if (w_is_r) begin
                    w_alu_src_b  = c_SRCB_B;
                    w_alu_op     = c_ALU_FUNCT;
                    w_next_state = S_WB;
                end else if (w_is_i) begin
                    w_alu_src_b  = c_SRCB_IMM;
                    w_alu_op     = c_ALU_FUNCT;
                    w_next_state = S_WB;
                end else if (w_is_load || w_is_store) begin
                    w_alu_src_b  = c_SRCB_IMM;
                    w_next_state = S_MEM;
                end else if (w_is_jalr) begin
                    w_alu_src_b  = c_SRCB_IMM;
                    w_next_state = S_WB;
                end else if (w_is_branch) begin
                    w_alu_src_b = c_SRCB_B;
                    w_alu_op    = c_ALU_BRANCH;
                    if (alu_bcond) begin
                        w_pc_write   = 1'b1;
                        w_pc_source  = 1'b1;
                        w_next_state = S_IF;
                    end else begin
                        w_next_state = S_PC4;
                    end
                end else begin
                    // Opcode no longer an EX class: retire it as a NOP.
                    w_next_state = S_PC4;
                end
            end

            S_MEM: begin
                w_i_or_d = 1'b1;
                if (w_is_load) begin
                    w_mem_read = 1'b1;
                    if (mem_ready)
                        w_next_state = S_WB;
                end else if (w_is_store) begin
                    w_mem_write = 1'b1;
                    w_alu_src_b = c_SRCB_4;
                    if (mem_ready) begin
                        w_pc_write   = 1'b1;
                        w_next_state = S_IF;
                    end
                end else begin
                    w_next_state = S_PC4;
                end
            end

            S_WB: begin
                w_alu_src_b  = c_SRCB_4;
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_mem_to_reg = w_is_load;
                w_pc_source  = w_is_jal || w_is_jalr;
                w_next_state = S_IF;
            end

            S_PC4: begin
                w_alu_src_b  = c_SRCB_4;
                w_pc_write   = 1'b1;
                w_next_state = S_IF;
            end

            S_HALT: w_next_state = S_HALT;

            default: w_next_state = S_IF;
        endcase

        if (!r_started)
            w_next_state = S_IF;
    end

    // Reset gates the outputs combinationally so an abort takes effect at once.
    assign w_live = reset & r_started;

    assign pc_write   = w_pc_write   & w_live;
    assign pc_source  = w_pc_source  & w_live;
    assign i_or_d     = w_i_or_d     & w_live;
    assign mem_read   = w_mem_read   & w_live;
    assign mem_write  = w_mem_write  & w_live;
    assign ir_write   = w_ir_write   & w_live;
    assign mem_to_reg = w_mem_to_reg & w_live;
    assign reg_write  = w_reg_write  & w_live;
    assign alu_src_a  = w_alu_src_a  & w_live;
    assign alu_src_b  = w_alu_src_b  & {2{w_live}};
    assign alu_op     = w_alu_op     & {2{w_live}};
    assign is_halted  = (r_state == S_HALT) & reset;
    assign state      = r_state;

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_retired_count;
    logic             w_retire;

    assign w_retire = w_pc_write || ((w_next_state == S_HALT) && (r_state != S_HALT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else if (r_started) begin
            if (r_state != S_HALT)
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_retire)
                r_retired_count <= r_retired_count + CNT_W'(1);
        end
    end

    assign cycle_count   = r_cycle_count;
    assign retired_count = r_retired_count;
`else
    assign cycle_count   = '0;
    assign retired_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control_fsm.sv
`default_nettype none
// Directed testbench for multi_cycle_control_fsm with a tiny PC/ALUOut
// datapath model driven by the control outputs.
module tb_multi_cycle_control_fsm;

    localparam int CNT_W = 32;
`ifdef MC_CTRL_PERF_CNT_EN
    localparam int c_PERF = 1;
`else
    localparam int c_PERF = 0;
`endif

    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_ECALL = 7'b1110011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    localparam logic [2:0] c_S_IF = 3'd0, c_S_ID = 3'd1, c_S_EX = 3'd2, c_S_MEM = 3'd3;
    localparam logic [2:0] c_S_WB = 3'd4, c_S_PC4 = 3'd5, c_S_HALT = 3'd6;

    // {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted}
    localparam logic [13:0] c_ZERO    = 14'b0;
    localparam logic [13:0] c_IF_RDY  = 14'b0_0_0_1_0_1_0_0_0_00_00_0;
    localparam logic [13:0] c_ID      = 14'b0_0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [13:0] c_EX_ALUI = 14'b0_0_0_0_0_0_0_0_1_10_10_0;
    localparam logic [13:0] c_EX_LS   = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [13:0] c_EX_BR_T = 14'b1_1_0_0_0_0_0_0_1_00_01_0;
    localparam logic [13:0] c_EX_BR_N = 14'b0_0_0_0_0_0_0_0_1_00_01_0;
    localparam logic [13:0] c_MEM_LW  = 14'b0_0_1_1_0_0_0_0_0_00_00_0;
    localparam logic [13:0] c_MEM_SW  = 14'b0_0_1_0_1_0_0_0_0_01_00_0;
    localparam logic [13:0] c_WB_ALU  = 14'b1_0_0_0_0_0_0_1_0_01_00_0;
    localparam logic [13:0] c_WB_LD   = 14'b1_0_0_0_0_0_1_1_0_01_00_0;
    localparam logic [13:0] c_WB_J    = 14'b1_1_0_0_0_0_0_1_0_01_00_0;
    localparam logic [13:0] c_PC4     = 14'b1_0_0_0_0_0_0_0_0_01_00_0;
    localparam logic [13:0] c_HALT    = 14'b0_0_0_0_0_0_0_0_0_00_00_1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [6:0]       opcode = c_OP_I;
    logic             alu_bcond = 1'b0;
    logic             x17_is_10 = 1'b0;
    logic             mem_ready = 1'b1;
    logic             pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_write, alu_src_a, is_halted;
    logic [1:0]       alu_src_b, alu_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_count, retired_count;
    logic [13:0]      ctl;

    assign ctl = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted};

    always #5 clk = ~clk;

    multi_cycle_control_fsm #(.CNT_W(CNT_W)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .alu_bcond     (alu_bcond),
        .x17_is_10     (x17_is_10),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .is_halted     (is_halted),
        .state         (state),
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Datapath model state
    logic [31:0] pc = 0, aluout = 0, a_reg = 0, b_reg = 0, imm = 0, mdr = 0, rd_val = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check state/controls, then advance the model.
    task automatic cyc(input string tag, input logic [6:0] op, input logic rdy,
                       input logic bc, input logic [2:0] exp_st, input logic [13:0] exp_ctl);
        logic [31:0] opa, opb, res, nxt_pc, nxt_rd;
        opcode = op; mem_ready = rdy; alu_bcond = bc;
        #1;
        check({tag, ".state"}, state, exp_st);
        check({tag, ".ctl"}, ctl, exp_ctl);
        opa = alu_src_a ? a_reg : pc;
        case (alu_src_b)
            2'b01:   opb = 32'd4;
            2'b10:   opb = imm;
            default: opb = b_reg;
        endcase
        res    = opa + opb;
        nxt_pc = pc_write ? (pc_source ? aluout : res) : pc;
        nxt_rd = rd_val;
        if (reg_write)
            nxt_rd = mem_to_reg ? mdr : ((op == c_OP_JAL || op == c_OP_JALR) ? res : aluout);
        @(posedge clk); #1;
        pc = nxt_pc; aluout = res; rd_val = nxt_rd;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
        check("release.idle_ctl", ctl, c_ZERO);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state, with mem_ready high to show mem_read is forced low
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", state, c_S_IF);
        check("rst.ctl", ctl, c_ZERO);
        check("rst.cycles", cycle_count, 0);
        check("rst.retired", retired_count, 0);
        release_reset();

        // ADDI x1,x0,5 at PC 0
        pc = 0; a_reg = 0; imm = 5;
        cyc("addi.if", c_OP_I, 1, 0, c_S_IF, c_IF_RDY);
        cyc("addi.id", c_OP_I, 1, 0, c_S_ID, c_ID);
        cyc("addi.ex", c_OP_I, 1, 0, c_S_EX, c_EX_ALUI);
        cyc("addi.wb", c_OP_I, 1, 0, c_S_WB, c_WB_ALU);
        check("addi.pc", pc, 32'd4);
        check("addi.rd", rd_val, 32'd5);
        check("addi.cycles", cycle_count, (c_PERF != 0) ? 4 : 0);
        check("addi.retired", retired_count, (c_PERF != 0) ? 1 : 0);

        // LW with two memory wait cycles; mem_ready low in ID/EX is ignored
        a_reg = 32'h100; imm = 8; mdr = 32'hABCD;
        cyc("lw.if",   c_OP_LOAD, 1, 0, c_S_IF,  c_IF_RDY);
        cyc("lw.id",   c_OP_LOAD, 0, 0, c_S_ID,  c_ID);
        cyc("lw.ex",   c_OP_LOAD, 0, 0, c_S_EX,  c_EX_LS);
        cyc("lw.mem0", c_OP_LOAD, 0, 0, c_S_MEM, c_MEM_LW);
        cyc("lw.mem1", c_OP_LOAD, 0, 0, c_S_MEM, c_MEM_LW);
        cyc("lw.mem2", c_OP_LOAD, 1, 0, c_S_MEM, c_MEM_LW);
        cyc("lw.wb",   c_OP_LOAD, 0, 0, c_S_WB,  c_WB_LD);
        check("lw.pc", pc, 32'd8);
        check("lw.rd", rd_val, 32'hABCD);

        // BEQ taken at PC 8, imm 16
        pc = 8; imm = 16;
        cyc("beqt.if", c_OP_BR, 1, 0, c_S_IF, c_IF_RDY);
        cyc("beqt.id", c_OP_BR, 1, 0, c_S_ID, c_ID);
        cyc("beqt.ex", c_OP_BR, 1, 1, c_S_EX, c_EX_BR_T);
        check("beqt.pc", pc, 32'd24);
        check("beqt.next", state, c_S_IF);

        // BEQ not taken at PC 8; bcond high in ID must not matter
        pc = 8;
        cyc("beqn.if",  c_OP_BR, 1, 1, c_S_IF,  c_IF_RDY);
        cyc("beqn.id",  c_OP_BR, 1, 1, c_S_ID,  c_ID);
        cyc("beqn.ex",  c_OP_BR, 1, 0, c_S_EX,  c_EX_BR_N);
        cyc("beqn.pc4", c_OP_BR, 1, 0, c_S_PC4, c_PC4);
        check("beqn.pc", pc, 32'd12);

        // JAL at PC 0x20, imm 0x100
        pc = 32'h20; imm = 32'h100;
        cyc("jal.if", c_OP_JAL, 1, 0, c_S_IF, c_IF_RDY);
        cyc("jal.id", c_OP_JAL, 1, 0, c_S_ID, c_ID);
        cyc("jal.wb", c_OP_JAL, 1, 0, c_S_WB, c_WB_J);
        check("jal.pc", pc, 32'h120);
        check("jal.rd", rd_val, 32'h24);

        // Unknown opcode runs as a NOP through PC4
        cyc("nop.if",  c_OP_LUI, 1, 0, c_S_IF,  c_IF_RDY);
        cyc("nop.id",  c_OP_LUI, 1, 0, c_S_ID,  c_ID);
        cyc("nop.pc4", c_OP_LUI, 1, 0, c_S_PC4, c_PC4);
        check("nop.pc", pc, 32'h124);

        // ECALL with x17 != 10 continues
        x17_is_10 = 1'b0;
        cyc("ecn.if",  c_OP_ECALL, 1, 0, c_S_IF,  c_IF_RDY);
        cyc("ecn.id",  c_OP_ECALL, 1, 0, c_S_ID,  c_ID);
        cyc("ecn.pc4", c_OP_ECALL, 1, 0, c_S_PC4, c_PC4);
        check("ecn.pc", pc, 32'h128);

        // SW stalled in MEM, then reset pulled low mid-cycle
        cyc("sw.if",   c_OP_STORE, 1, 0, c_S_IF,  c_IF_RDY);
        cyc("sw.id",   c_OP_STORE, 1, 0, c_S_ID,  c_ID);
        cyc("sw.ex",   c_OP_STORE, 1, 0, c_S_EX,  c_EX_LS);
        cyc("sw.mem0", c_OP_STORE, 0, 0, c_S_MEM, c_MEM_SW);
        #1;
        check("sw.mem_write_pre", mem_write, 1'b1);
        reset = 1'b0;
        #1;
        check("sw.abort_ctl", ctl, c_ZERO);
        check("sw.abort_state", state, c_S_IF);
        check("sw.abort_cycles", cycle_count, 0);
        check("sw.abort_retired", retired_count, 0);
        @(posedge clk); #1;
        release_reset();

        // ECALL with x17 == 10 halts
        x17_is_10 = 1'b1;
        cyc("ech.if", c_OP_ECALL, 1, 0, c_S_IF, c_IF_RDY);
        cyc("ech.id", c_OP_ECALL, 1, 0, c_S_ID, c_ID);
        check("ech.state", state, c_S_HALT);
        check("ech.ctl", ctl, c_HALT);
        x17_is_10 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            mem_ready = i[0];
            @(posedge clk); #1;
            check("halt.sticky", is_halted, 1'b1);
        end
        check("halt.cycles", cycle_count, (c_PERF != 0) ? 2 : 0);
        check("halt.retired", retired_count, (c_PERF != 0) ? 1 : 0);
        reset = 1'b0;
        #1;
        check("halt.rst_flag", is_halted, 1'b0);
        check("halt.rst_state", state, c_S_IF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
